mt_thread_sched: RTL and testbench
==================================

// Module: mt_thread_sched
// PURPOSE
//  Parametrised thread scheduler / PC bank for the barrel pipeline; replaces the fixed 8-thread round-robin
//  thread selection in the fetch stage. Holds one PC and one active bit per hardware thread.
//  Each cycle it selects one thread and presents {tid, pc, pc+4} to instruction fetch.
//  Modes: strict barrel, or skip-idle with a per-thread minimum issue gap. Accepts branch redirects, halt and start.
// PARAMETERS
//  ADDRESS_WIDTH    32                     PC width
//  NUM_THREADS      8                      hardware threads, >=2, need not be a power of 2
//  BITS_THREADS     $clog2(NUM_THREADS)    tid width
//  RESET_PC         0                      reset PC of thread 0
//  THREAD_PC_STRIDE 0                      reset PC of thread t = RESET_PC + t*THREAD_PC_STRIDE
//  SKIP_IDLE        0                      0 = strict barrel slots; 1 = skip ineligible threads
//  MIN_GAP          5                      SKIP_IDLE=1 only: min cycles between issues of one thread, >=1
// PORTS
//  clk             in   1              clock, rising edge
//  rst             in   1              reset: synchronous, active-high
//  thread_en       in   NUM_THREADS    per-thread issue enable mask (level)
//  redirect_valid  in   1              taken branch/jump resolved (pc_src_e)
//  redirect_tid    in   BITS_THREADS   thread of redirect
//  redirect_pc     in   ADDRESS_WIDTH  redirect target
//  halt_valid      in   1              thread retires a halt
//  halt_tid        in   BITS_THREADS   thread to deactivate
//  start_valid     in   1              wake thread
//  start_tid       in   BITS_THREADS   thread to activate
//  start_pc        in   ADDRESS_WIDTH  new PC for started thread
//  fetch_valid     out  1              issue slot holds a real thread
//  fetch_tid       out  BITS_THREADS   issued thread
//  fetch_pc        out  ADDRESS_WIDTH  issued PC
//  fetch_pc_plus4  out  ADDRESS_WIDTH  fetch_pc + 4, modulo 2^ADDRESS_WIDTH
//  active_mask     out  NUM_THREADS    registered active bits
//  all_halted      out  1              active_mask == 0
// BEHAVIOUR
//  Reset: pc[t] = RESET_PC + t*THREAD_PC_STRIDE; active = all ones; rr_ptr = 0; cooldown = 0.
//   fetch_valid = 0, fetch_tid = 0, fetch_pc = 0, fetch_pc_plus4 = 0. rst mid-operation discards all state in one edge.
//  elig[t] = active[t] & thread_en[t] & ~(halt_valid & halt_tid==t). Selection uses current registers.
//   fetch_* are registered: the selection made at edge k is visible on fetch_* after edge k.
//  SKIP_IDLE=0: candidate = rr_ptr. rr_ptr advances every cycle, wrapping from NUM_THREADS-1 to 0.
//   fetch_valid = elig[candidate]. An ineligible slot is a bubble that keeps its tid. Cooldown is unused.
//  SKIP_IDLE=1: candidate = first t scanning from rr_ptr upward (wrapping) with elig[t] & cooldown[t]==0.
//   If a candidate is found: issue it and set rr_ptr = candidate+1 (wrap). Otherwise: bubble, rr_ptr held, fetch_tid held.
//   On issue, cooldown[t] = MIN_GAP-1; every nonzero cooldown decrements by 1 per cycle.
//   A lone thread therefore issues once every MIN_GAP cycles.
//  Issue: issued pc = pc[t], and pc[t] <= pc[t]+4 (wraps at 2^ADDRESS_WIDTH).
//   Redirect bypass: if redirect_valid and redirect_tid==t in the issue cycle, issued pc = redirect_pc
//   and pc[t] <= redirect_pc+4.
//  Redirect without issue: pc[redirect_tid] <= redirect_pc. Redirect does not change active.
//  Halt: active[halt_tid] <= 0. The same tid is not issued in that cycle. pc[halt_tid] keeps any same-cycle redirect.
//  Start: active[start_tid] <= 1; pc[start_tid] <= start_pc; cooldown[start_tid] <= 0.
//   Start is not bypassed: the thread becomes eligible next cycle.
//  Same tid, same cycle: start overrides halt and redirect (both active and pc).
//   Different tids are fully independent.
//  thread_en gates issue only; it does not change active or pc.
// TESTING
//  SKIP_IDLE=0, N=8, stride 0x100: release rst -> tids 0..7, pcs 0x000..0x700 valid, then tid0 pc 0x004.
//  SKIP_IDLE=0, thread_en=8'hFB -> slot tid2 has fetch_valid=0 every 8th cycle; the other slots are unchanged.
//  SKIP_IDLE=1, MIN_GAP=5, only thread 3 enabled -> valid tid3 every 5 cycles, pc +4 each issue.
//   Other cycles are bubbles.
//  redirect_valid, tid=3, pc=0x200 in the cycle tid3 is selected -> issued pc 0x200, next tid3 pc 0x204.
//  halt tid 5, start tid 5 pc 0x40 same cycle -> active[5]=1, next tid5 issue pc 0x40.
//   Then halt all threads -> all_halted=1, fetch_valid=0.
//  N=6 (non power of 2) strict mode -> tid wraps 5->0. Assert rst mid-stream -> next edge restores reset values.

Source files
------------

// File: rtl/mt_thread_sched.sv
// Thread scheduler and PC bank for the barrel pipeline.
// Holds one PC and one active bit per hardware thread. Each cycle it picks a
// thread and registers {tid, pc, pc+4} toward instruction fetch. It runs either
// as a strict barrel (fixed round-robin slots) or in skip-idle mode, where a
// per-thread cooldown enforces a minimum issue gap.
module mt_thread_sched #(
  parameter int                       ADDRESS_WIDTH    = 32,
  parameter int                       NUM_THREADS      = 8,
  parameter int                       BITS_THREADS     = $clog2(NUM_THREADS),
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = '0,
  parameter bit                       SKIP_IDLE        = 1'b0,
  parameter int                       MIN_GAP          = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   thread_en,
  input  logic                     redirect_valid,
  input  logic [BITS_THREADS-1:0]  redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_valid,
  input  logic [BITS_THREADS-1:0]  halt_tid,
  input  logic                     start_valid,
  input  logic [BITS_THREADS-1:0]  start_tid,
  input  logic [ADDRESS_WIDTH-1:0] start_pc,
  output logic                     fetch_valid,
  output logic [BITS_THREADS-1:0]  fetch_tid,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc_plus4,
  output logic [NUM_THREADS-1:0]   active_mask,
  output logic                     all_halted
);

  // Cooldown counters only need to hold MIN_GAP-1.
  localparam int                      CD_W     = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CD_W-1:0]         CD_LOAD  = CD_W'(MIN_GAP - 1);
  localparam logic [BITS_THREADS-1:0] LAST_TID = BITS_THREADS'(NUM_THREADS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_INC  = ADDRESS_WIDTH'(4);

  // Architectural per-thread state.
  logic [ADDRESS_WIDTH-1:0] pc_q       [NUM_THREADS];
  logic [CD_W-1:0]          cooldown_q [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active_q;
  logic [BITS_THREADS-1:0]  rr_ptr_q;

  // Selection results for the current cycle.
  logic [NUM_THREADS-1:0]   elig;
  logic                     issue;
  logic [BITS_THREADS-1:0]  cand;
  logic [ADDRESS_WIDTH-1:0] issue_pc;
  logic [BITS_THREADS-1:0]  rr_next;

  // Round-robin successor that wraps at NUM_THREADS-1, so non power-of-2
  // thread counts never visit an unused tid.
  function automatic logic [BITS_THREADS-1:0] next_tid(input logic [BITS_THREADS-1:0] tid);
    return (tid == LAST_TID) ? '0 : tid + BITS_THREADS'(1);
  endfunction

  // A thread is eligible when active, enabled, and not retiring a halt this cycle.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      elig[t] = active_q[t] & thread_en[t] &
                ~(halt_valid & (halt_tid == BITS_THREADS'(t)));
    end
  end

  // Pick the thread for this slot: fixed slot in barrel mode, first ready
  // thread at or after rr_ptr in skip-idle mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    issue = 1'b0;
    cand  = rr_ptr_q;
    if (SKIP_IDLE) begin
      // Scan offsets from farthest to nearest so the nearest ready thread
      // is the last assignment and wins, without a break flag.
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
        int idx;
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
        if (elig[idx] && (cooldown_q[idx] == '0)) begin
          issue = 1'b1;
          cand  = BITS_THREADS'(idx);
        end
      end
    end else begin
      issue = elig[rr_ptr_q];
    end
  end

  // Issued PC with same-cycle redirect bypass, and the next round-robin pointer.
  always_comb begin
    issue_pc = pc_q[cand];
    if (redirect_valid && (redirect_tid == cand)) issue_pc = redirect_pc;
    if (SKIP_IDLE) rr_next = issue ? next_tid(cand) : rr_ptr_q;
    else           rr_next = next_tid(rr_ptr_q);
  end

  // Fetch-slot registers and scheduler pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      rr_ptr_q       <= '0;
      fetch_valid    <= 1'b0;
      fetch_tid      <= '0;
      fetch_pc       <= '0;
      fetch_pc_plus4 <= '0;
    end else begin
      rr_ptr_q    <= rr_next;
      fetch_valid <= issue;
      // A strict-barrel bubble still reports its slot tid; skip-idle holds it.
      if (issue || !SKIP_IDLE) fetch_tid <= cand;
      if (issue) begin
        fetch_pc       <= issue_pc;
        fetch_pc_plus4 <= issue_pc + PC_INC;
      end
    end
  end

  // Per-thread PC, active bit and cooldown; start overrides halt and redirect
  // for the same tid, different tids never interact.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the PC bank is a register array, not RAM, and must be reset
      // because every thread's start address is architecturally defined.
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc_q[t]       <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_STRIDE;
        cooldown_q[t] <= '0;
      end
      active_q <= '1;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        logic hit_issue;
        hit_issue = issue && (cand == BITS_THREADS'(t));
        if (start_valid && (start_tid == BITS_THREADS'(t))) begin
          active_q[t]   <= 1'b1;
          pc_q[t]       <= start_pc;
          cooldown_q[t] <= '0;
        end else begin
          if (halt_valid && (halt_tid == BITS_THREADS'(t))) active_q[t] <= 1'b0;
          if (hit_issue)
            pc_q[t] <= issue_pc + PC_INC;
          else if (redirect_valid && (redirect_tid == BITS_THREADS'(t)))
            pc_q[t] <= redirect_pc;
          if (SKIP_IDLE && hit_issue)
            cooldown_q[t] <= CD_LOAD;
          else if (cooldown_q[t] != '0)
            cooldown_q[t] <= cooldown_q[t] - CD_W'(1);
        end
      end
    end
  end

  assign active_mask = active_q;
  assign all_halted  = (active_q == '0);

endmodule

// File: tb/tb_mt_thread_sched.sv
// Testbench for mt_thread_sched: three instances (strict N=8, strict N=6,
// skip-idle N=8 MIN_GAP=5) share one stimulus stream. A behavioural model
// predicts each instance's outputs; predictions are queued by the driver and
// popped and compared by an independent monitor after every clock edge.
module tb_mt_thread_sched;

  localparam int GAP = 5;

  typedef struct packed {
    logic [7:0][31:0] pc;
    logic [7:0]       act;
    logic [7:0][7:0]  cd;
    logic [3:0]       ptr;
    logic             fv;
    logic [2:0]       ft;
    logic [31:0]      fpc;
    logic [31:0]      fpc4;
  } mst_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en;
  logic        rv, hv, sv;
  logic [2:0]  rt, ht, st;
  logic [31:0] rpc, spc;

  logic        b_fv, s_fv, k_fv;
  logic [2:0]  b_ft, s_ft, k_ft;
  logic [31:0] b_pc, s_pc, k_pc, b_pc4, s_pc4, k_pc4;
  logic [7:0]  b_am, k_am;
  logic [5:0]  s_am;
  logic        b_ah, s_ah, k_ah;

  int n_checks = 0;
  int n_errors = 0;

  int          cfg_n      [3] = '{8, 6, 8};
  bit          cfg_skip   [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] cfg_base   [3] = '{32'h0, 32'h0, 32'h1000};
  logic [31:0] cfg_stride [3] = '{32'h100, 32'h100, 32'h40};

  mst_t m [3];
  mst_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  mt_thread_sched #(.NUM_THREADS(8), .THREAD_PC_STRIDE(32'h100), .SKIP_IDLE(1'b0)) u_bar (
    .clk(clk), .rst(rst), .thread_en(en),
    .redirect_valid(rv), .redirect_tid(rt), .redirect_pc(rpc),
    .halt_valid(hv), .halt_tid(ht), .start_valid(sv), .start_tid(st), .start_pc(spc),
    .fetch_valid(b_fv), .fetch_tid(b_ft), .fetch_pc(b_pc), .fetch_pc_plus4(b_pc4),
    .active_mask(b_am), .all_halted(b_ah));

  mt_thread_sched #(.NUM_THREADS(6), .THREAD_PC_STRIDE(32'h100), .SKIP_IDLE(1'b0)) u_six (
    .clk(clk), .rst(rst), .thread_en(en[5:0]),
    .redirect_valid(rv), .redirect_tid(rt), .redirect_pc(rpc),
    .halt_valid(hv), .halt_tid(ht), .start_valid(sv), .start_tid(st), .start_pc(spc),
    .fetch_valid(s_fv), .fetch_tid(s_ft), .fetch_pc(s_pc), .fetch_pc_plus4(s_pc4),
    .active_mask(s_am), .all_halted(s_ah));

  mt_thread_sched #(.NUM_THREADS(8), .RESET_PC(32'h1000), .THREAD_PC_STRIDE(32'h40),
                    .SKIP_IDLE(1'b1), .MIN_GAP(GAP)) u_skp (
    .clk(clk), .rst(rst), .thread_en(en),
    .redirect_valid(rv), .redirect_tid(rt), .redirect_pc(rpc),
    .halt_valid(hv), .halt_tid(ht), .start_valid(sv), .start_tid(st), .start_pc(spc),
    .fetch_valid(k_fv), .fetch_tid(k_ft), .fetch_pc(k_pc), .fetch_pc_plus4(k_pc4),
    .active_mask(k_am), .all_halted(k_ah));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_t reset_state(input int n, input logic [31:0] base, input logic [31:0] stride);
    mst_t r;
    r = '0;
    for (int t = 0; t < n; t++) begin
      r.pc[t]  = base + stride * t;
      r.act[t] = 1'b1;
    end
    return r;
  endfunction

  // One clock of the scheduler rules, expressed over plain arrays and ints.
  function automatic mst_t model_step(input mst_t s, input int k);
    mst_t        r;
    int          n, cand;
    bit   [7:0]  elig;
    bit          found;
    logic [31:0] ipc;
    n = cfg_n[k];
    if (rst) return reset_state(n, cfg_base[k], cfg_stride[k]);
    r = s;
    elig = '0;
    for (int t = 0; t < n; t++)
      elig[t] = s.act[t] && en[t] && !(hv && int'(ht) == t);
    found = 1'b0;
    cand  = int'(s.ptr);
    if (!cfg_skip[k]) begin
      found = elig[cand];
      r.ft  = 3'(cand);
      r.ptr = 4'((cand + 1) % n);
    end else begin
      for (int i = 0; i < n; i++) begin
        int c;
        c = (int'(s.ptr) + i) % n;
        if (!found && elig[c] && s.cd[c] == 0) begin
          found = 1'b1;
          cand  = c;
        end
      end
      for (int t = 0; t < n; t++)
        if (s.cd[t] != 0) r.cd[t] = s.cd[t] - 8'd1;
      if (found) begin
        r.ft       = 3'(cand);
        r.ptr      = 4'((cand + 1) % n);
        r.cd[cand] = 8'(GAP - 1);
      end
    end
    r.fv = found;
    if (rv && int'(rt) < n) r.pc[rt] = rpc;
    if (found) begin
      ipc        = (rv && int'(rt) == cand) ? rpc : s.pc[cand];
      r.fpc      = ipc;
      r.fpc4     = ipc + 32'd4;
      r.pc[cand] = ipc + 32'd4;
    end
    if (hv && int'(ht) < n) r.act[ht] = 1'b0;
    if (sv && int'(st) < n) begin
      r.act[st] = 1'b1;
      r.pc[st]  = spc;
      r.cd[st]  = 8'd0;
    end
    return r;
  endfunction

  // Advance the model with the inputs currently driven, queue the
  // predictions, then move to the next drive point and clear pulses.
  task automatic cycle();
    for (int k = 0; k < 3; k++) m[k] = model_step(m[k], k);
    q0.push_back(m[0]);
    q1.push_back(m[1]);
    q2.push_back(m[2]);
    @(negedge clk);
    rv = 1'b0;
    hv = 1'b0;
    sv = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  task automatic cmp(input string nm, input mst_t e, input int n,
                     input logic fv, input logic [2:0] ft, input logic [31:0] fpc,
                     input logic [31:0] fpc4, input logic [7:0] am, input logic ah);
    logic [7:0] mask;
    mask = 8'((1 << n) - 1);
    check({nm, ".fetch_valid"}, 32'(fv), 32'(e.fv));
    check({nm, ".fetch_tid"}, 32'(ft), 32'(e.ft));
    if (e.fv) begin
      check({nm, ".fetch_pc"}, fpc, e.fpc);
      check({nm, ".fetch_pc_plus4"}, fpc4, e.fpc4);
    end
    check({nm, ".active_mask"}, 32'(am & mask), 32'(e.act & mask));
    check({nm, ".all_halted"}, 32'(ah), 32'((e.act & mask) == 8'h0));
  endtask

  // Monitor: compare each instance against its queued prediction after every edge.
  initial begin
    mst_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp("bar8", e, 8, b_fv, b_ft, b_pc, b_pc4, b_am, b_ah); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp("bar6", e, 6, s_fv, s_ft, s_pc, s_pc4, {2'b00, s_am}, s_ah); end
      if (q2.size() > 0) begin e = q2.pop_front(); cmp("skip8", e, 8, k_fv, k_ft, k_pc, k_pc4, k_am, k_ah); end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver: directed phases followed by randomized traffic.
  initial begin
    int waited;
    rst = 1'b1; en = 8'hFF;
    rv = 1'b0; rt = '0; rpc = '0;
    hv = 1'b0; ht = '0;
    sv = 1'b0; st = '0; spc = '0;
    for (int k = 0; k < 3; k++) m[k] = '0;
    run(2);

    // Release reset: barrel order with strided reset PCs, wrap and second lap.
    rst = 1'b0;
    run(20);

    // Thread 2 masked: its slot becomes a bubble.
    en = 8'hFB;
    run(16);

    // Only thread 3 enabled: skip-idle issues it once every GAP cycles.
    en = 8'h08;
    run(22);

    // Redirect thread 3 to 0x200 exactly when the barrel slot selects it.
    en = 8'hFF;
    waited = 0;
    while (m[0].ptr != 4'd3 && waited < 16) begin
      cycle();
      waited++;
    end
    check("redirect_align", 32'(m[0].ptr), 32'd3);
    rv = 1'b1; rt = 3'd3; rpc = 32'h200;
    run(12);

    // Halt and start thread 5 in the same cycle: start wins.
    hv = 1'b1; ht = 3'd5; sv = 1'b1; st = 3'd5; spc = 32'h40;
    run(12);

    // Halt every thread, then idle: all halted, no valid slots.
    for (int t = 0; t < 8; t++) begin
      hv = 1'b1; ht = 3'(t);
      cycle();
    end
    run(8);

    // Mid-stream reset restores reset values in one edge.
    sv = 1'b1; st = 3'd1; spc = 32'h80;
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      en  = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 3) == 0);
      rt  = 3'($urandom);
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      hv  = ($urandom_range(0, 7) == 0);
      ht  = 3'($urandom);
      sv  = ($urandom_range(0, 5) == 0);
      st  = 3'($urandom);
      spc = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    rst = 1'b0;
    en  = 8'hFF;
    run(4);

    @(posedge clk);
    #2;
    check("drain_bar8", 32'(q0.size()), 32'd0);
    check("drain_bar6", 32'(q1.size()), 32'd0);
    check("drain_skip8", 32'(q2.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
